// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: comparator state encoding and the state-to-verdict mapping
// shared by the framed serial comparator.
package serial_cmp_pkg;
  typedef enum logic [1:0] {ST_EQUAL = 2'b00, ST_LESS = 2'b01, ST_GREATER = 2'b10} cmp_state_t;
  function automatic logic [2:0] verdict_of(input cmp_state_t s);
    return {s == ST_LESS, s == ST_EQUAL, s == ST_GREATER};
  endfunction
endpackage

// File: rtl/serial_cmp_digit.sv
// serial_cmp_digit: unsigned digit compare; invert_top flips the top bit of
// both operands so the sign digit orders as two's complement.
module serial_cmp_digit #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               invert_top,
  output logic               d_lt,
  output logic               d_gt
);
  logic [DIGIT_W-1:0] flip, ax, bx;
  assign flip = DIGIT_W'(invert_top) << (DIGIT_W - 1);
  assign ax = a ^ flip;
  assign bx = b ^ flip;
  assign d_lt = ax < bx;
  assign d_gt = ax > bx;
endmodule

// File: rtl/serial_comparator_framed_multidigit.sv
// serial_comparator_framed_multidigit: framed multi-digit serial magnitude compare.
// Optional SERIAL_CMP_SIGNED_EN adds signed_mode for two's-complement ordering.
module serial_comparator_framed_multidigit
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W    = 1,
  parameter int MAX_DIGITS = 16,
  parameter int MSB_FIRST  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
`ifdef SERIAL_CMP_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b,
  output logic               res_valid,
  output logic               res_less,
  output logic               res_eq,
  output logic               res_greater,
  output logic               len_err
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  cmp_state_t state, cmp_state;
  logic [CW-1:0] beat_cnt;
  logic d_lt, d_gt, invert_top, implicit_end, frame_end;
  assign implicit_end = beat_cnt == CW'(MAX_DIGITS - 1);
  assign frame_end = in_valid && (in_last || implicit_end);
`ifdef SERIAL_CMP_SIGNED_EN
  // The sign digit is the first beat MSB-first, the frame-end beat LSB-first.
  assign invert_top = signed_mode && ((MSB_FIRST != 0) ? beat_cnt == '0 : (in_last || implicit_end));
`else
  assign invert_top = 1'b0;
`endif
  serial_cmp_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a(a), .b(b), .invert_top(invert_top), .d_lt(d_lt), .d_gt(d_gt)
  );
  // MSB-first locks on the first difference; LSB-first lets later digits override.
  always_comb begin
    cmp_state = state;
    if (MSB_FIRST == 0 || state == ST_EQUAL)
      cmp_state = d_lt ? ST_LESS : d_gt ? ST_GREATER : state;
  end
  assign {a_less_b, a_eq_b, a_greater_b} = verdict_of(in_valid ? cmp_state : state);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_EQUAL;
      beat_cnt <= '0;
      res_valid <= 1'b0;
      {res_less, res_eq, res_greater} <= 3'b000;
      len_err <= 1'b0;
    end else begin
      res_valid <= frame_end;
      if (in_valid) begin
        state <= frame_end ? ST_EQUAL : cmp_state;
        beat_cnt <= frame_end ? '0 : beat_cnt + 1'b1;
      end
      if (frame_end) begin
        {res_less, res_eq, res_greater} <= {a_less_b, a_eq_b, a_greater_b};
        len_err <= implicit_end && !in_last;
      end
    end
  end
endmodule

// File: tb/tb_serial_comparator_framed_multidigit.sv
// tb_serial_comparator_framed_multidigit: directed table-driven checks of three
// comparator configurations plus multi-cycle corner sequences.
module tb_serial_comparator_framed_multidigit;
  localparam logic [2:0] LT = 3'b100, EQ = 3'b010, GT = 3'b001;
  logic clk = 1'b0, rst = 1'b1;
  logic v = 1'b0, l = 1'b0, a1 = 1'b0, b1 = 1'b0, a0 = 1'b0, b0 = 1'b0;
  logic v4 = 1'b0, l4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [2:0] run1, run0, run4, res1, res0, res4;
  logic rv1, rv0, rv4, le1, le0, le4;
`ifdef SERIAL_CMP_SIGNED_EN
  logic sm = 1'b0;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  serial_comparator_framed_multidigit #(.DIGIT_W(1), .MAX_DIGITS(16), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v), .in_last(l), .a(a1), .b(b1),
`ifdef SERIAL_CMP_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .a_less_b(run1[2]), .a_eq_b(run1[1]), .a_greater_b(run1[0]), .res_valid(rv1),
    .res_less(res1[2]), .res_eq(res1[1]), .res_greater(res1[0]), .len_err(le1));
  serial_comparator_framed_multidigit #(.DIGIT_W(1), .MAX_DIGITS(16), .MSB_FIRST(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(v), .in_last(l), .a(a0), .b(b0),
`ifdef SERIAL_CMP_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .a_less_b(run0[2]), .a_eq_b(run0[1]), .a_greater_b(run0[0]), .res_valid(rv0),
    .res_less(res0[2]), .res_eq(res0[1]), .res_greater(res0[0]), .len_err(le0));
  serial_comparator_framed_multidigit #(.DIGIT_W(4), .MAX_DIGITS(16), .MSB_FIRST(1)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_last(l4), .a(a4), .b(b4),
`ifdef SERIAL_CMP_SIGNED_EN
    .signed_mode(sm),
`endif
    .a_less_b(run4[2]), .a_eq_b(run4[1]), .a_greater_b(run4[0]), .res_valid(rv4),
    .res_less(res4[2]), .res_eq(res4[1]), .res_greater(res4[0]), .len_err(le4));

  typedef struct {logic l; logic a1, b1; logic [2:0] e1; logic a0, b0; logic [2:0] e0;} v1_t;
  typedef struct {logic v, l; logic [3:0] a, b; logic [2:0] er; logic rv; logic [2:0] eres;} v4_t;
  v1_t t1[16];
  v4_t t4[10];

  task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic logic [2:0] dec(input byte c);
    return c == "L" ? LT : c == "G" ? GT : EQ;
  endfunction

  initial begin
    logic [15:0] ka, kb;
    logic [7:0] k55;
    string s1, s0;
    ka = 16'h6482; kb = 16'h6262; k55 = 8'h55;
    s1 = "EEEEEGGGGGGGGGGG";
    s0 = "EEEEELLGGLGGGGGG";
    for (int k = 0; k < 16; k++)
      t1[k] = '{k == 15, ka[15-k], kb[15-k], dec(s1[k]), ka[k], kb[k], dec(s0[k])};
    t4 = '{
      '{1, 0, 4'h6, 4'h6, EQ, 0, EQ}, '{1, 0, 4'h4, 4'h2, GT, 0, EQ},
      '{0, 1, 4'hf, 4'h0, GT, 0, EQ}, '{1, 0, 4'h8, 4'h6, GT, 0, EQ},
      '{1, 1, 4'h2, 4'h2, GT, 0, EQ}, '{1, 0, 4'h0, 4'h0, EQ, 1, GT},
      '{1, 0, 4'h0, 4'h0, EQ, 0, GT}, '{1, 0, 4'h0, 4'h0, EQ, 0, GT},
      '{1, 1, 4'h1, 4'h2, LT, 0, GT}, '{0, 0, 4'h0, 4'h0, EQ, 1, LT}};
    #1 rst = 1'b0;
    #2;
    chk("reset_run1", run1, EQ); chk("reset_rv1", rv1, 0); chk("reset_res1", res1, 0);
    chk("reset_le1", le1, 0); chk("reset_run4", run4, EQ); chk("reset_res4", res4, 0);
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      v = 1; l = t1[k].l; a1 = t1[k].a1; b1 = t1[k].b1; a0 = t1[k].a0; b0 = t1[k].b0;
      #1 chk($sformatf("msb_run_%0d", k), run1, t1[k].e1);
      chk($sformatf("lsb_run_%0d", k), run0, t1[k].e0);
      if (k < 15) chk("no_early_rv", rv1, 0);
    end
    @(negedge clk); v = 0; l = 0;
    #1 chk("msb_rv", rv1, 1); chk("msb_res", res1, GT); chk("msb_le", le1, 0);
    chk("lsb_rv", rv0, 1); chk("lsb_res", res0, GT); chk("idle_run_eq", run1, EQ);
    @(negedge clk);
    #1 chk("rv_pulse_end", rv1, 0); chk("res_held", res1, GT);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      v4 = t4[k].v; l4 = t4[k].l; a4 = t4[k].a; b4 = t4[k].b;
      #1 chk($sformatf("dw4_run_%0d", k), run4, t4[k].er);
      chk($sformatf("dw4_rv_%0d", k), rv4, t4[k].rv);
      if (t4[k].rv) begin
        chk($sformatf("dw4_res_%0d", k), res4, t4[k].eres);
        chk($sformatf("dw4_le_%0d", k), le4, 0);
      end
    end
    v4 = 0; l4 = 0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      v = 1; l = k == 16; a1 = k == 16; b1 = 0; a0 = 0; b0 = 0;
      #1;
      if (k == 15) chk("len_rv_before", rv1, 0);
      if (k == 16) begin
        chk("len_rv", rv1, 1); chk("len_res", res1, EQ); chk("len_err", le1, 1);
        chk("newframe_run", run1, GT);
      end
    end
    @(negedge clk); v = 0; l = 0;
    #1 chk("newframe_rv", rv1, 1); chk("newframe_res", res1, GT); chk("newframe_le", le1, 0);
    @(negedge clk); v = 1; a1 = 1; b1 = 0;
    #1 chk("pre_reset_run", run1, GT);
    @(negedge clk); v = 0;
    #1 rst = 1'b0;
    #1 chk("async_run", run1, EQ); chk("async_res1", res1, 0); chk("async_rv", rv1, 0);
    chk("async_res4", res4, 0);
    @(negedge clk) rst = 1'b1;
    #1 chk("post_reset_rv", rv1, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v = 1; l = k == 7; a1 = k55[7-k]; b1 = k55[7-k];
    end
    @(negedge clk); v = 0; l = 0;
    #1 chk("r55_rv", rv1, 1); chk("r55_res", res1, EQ);
`ifdef SERIAL_CMP_SIGNED_EN
    for (int m = 1; m >= 0; m--) begin
      @(negedge clk); sm = m[0]; v4 = 1; l4 = 0; a4 = 4'h8; b4 = 4'h0;
      @(negedge clk); l4 = 1; a4 = 4'h0; b4 = 4'h1;
      @(negedge clk); v4 = 0; l4 = 0;
      #1 chk($sformatf("signed_rv_%0d", m), rv4, 1);
      chk($sformatf("signed_res_%0d", m), res4, m ? LT : GT);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
